// File: rtl/stage2_pkg.sv
// stage2_pkg: shared state encoding and width/timeout defaults for the memory-access stage
package stage2_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam int DATA_W_DEF  = 16;
  localparam int ADDR_W_DEF  = 16;
  localparam int TIMEOUT_DEF = 255;
endpackage

// File: rtl/mem_handshake_fsm.sv
// mem_handshake_fsm: IDLE/ACCESS/DONE req-ready sequencer with registered req/busy/done/err
module mem_handshake_fsm
  import stage2_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic ready,
  output logic accept,
  output logic complete,
  output logic req,
  output logic busy,
  output logic done,
  output logic err
);
  state_t state;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [CW-1:0] cnt;
`endif
  assign accept   = start && state != ACCESS;
  assign complete = state == ACCESS && ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (accept) begin
      state <= ACCESS;
      req   <= 1'b1;
      busy  <= 1'b1;
      done  <= 1'b0;
      err   <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      cnt   <= '0;
`endif
    end else if (complete) begin
      state <= DONE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
    end else if (state == ACCESS && cnt == CW'(TIMEOUT - 1)) begin
      state <= DONE;
      req   <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b1;
      err   <= 1'b1;
    end else if (state == ACCESS) begin
      cnt   <= cnt + 1'b1;
`endif
    end else if (state == DONE) begin
      state <= IDLE;
      done  <= 1'b0;
    end
endmodule

// File: rtl/stage2_register.sv
// stage2_register: enabled register with async active-low clear
//   clk, rst_n, en in; d[W] in; q[W] out
module stage2_register #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/stage2_mem_access.sv
// stage2_mem_access: memory-access stage; one req/ready transaction per accepted start, MDR/IR capture
module stage2_mem_access
  import stage2_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic              mem_start,
  input  logic              mem_we,
  input  logic              IRw,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_req,
  output logic              mem_wen,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] mdr_out,
  output logic [DATA_W-1:0] mem_out,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err
);
  logic       accept, complete;
  logic [1:0] ctl;
  mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk(CLK), .rst_n(reset), .start(mem_start), .ready(mem_ready),
    .accept(accept), .complete(complete), .req(mem_req), .busy(mem_busy),
    .done(mem_done), .err(mem_err)
  );
  stage2_register #(.W(ADDR_W)) u_addr (.clk(CLK), .rst_n(reset), .en(accept), .d(addr_in), .q(mem_addr));
  stage2_register #(.W(DATA_W)) u_wdata (.clk(CLK), .rst_n(reset), .en(accept), .d(wdata_in), .q(mem_wdata));
  stage2_register #(.W(2)) u_ctl (.clk(CLK), .rst_n(reset), .en(accept), .d({mem_we, IRw}), .q(ctl));
  assign mem_wen = ctl[1];
  stage2_register #(.W(DATA_W)) u_mdr (.clk(CLK), .rst_n(reset), .en(complete && !ctl[1]), .d(mem_rdata), .q(mdr_out));
  stage2_register #(.W(DATA_W)) u_ir (.clk(CLK), .rst_n(reset), .en(complete && !ctl[1] && ctl[0]), .d(mem_rdata), .q(ir_out));
  assign mem_out = mdr_out;
endmodule

// File: tb/tb_stage2_mem_access.sv
// tb_stage2_mem_access: self-checking bench for the memory-access stage
module tb_stage2_mem_access;
  logic        CLK = 0, reset = 0;
  logic [15:0] addr_in = 0, wdata_in = 0, mem_rdata = 0;
  logic        mem_start = 0, mem_we = 0, IRw = 0, mem_ready = 0;
  logic [15:0] mem_addr, mem_wdata, ir_out, mdr_out, mem_out;
  logic        mem_req, mem_wen, mem_busy, mem_done, mem_err;
  int tests = 0, fails = 0;
  stage2_mem_access #(.TIMEOUT(4)) dut (
    .CLK(CLK), .reset(reset), .addr_in(addr_in), .wdata_in(wdata_in), .mem_start(mem_start),
    .mem_we(mem_we), .IRw(IRw), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_req(mem_req), .mem_wen(mem_wen),
    .ir_out(ir_out), .mdr_out(mdr_out), .mem_out(mem_out), .mem_busy(mem_busy),
    .mem_done(mem_done), .mem_err(mem_err)
  );
  always #5 CLK = ~CLK;
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic test_reset();
    #2;
    tests++; if ({mem_req, mem_busy, mem_done, mem_err, mem_wen} !== 5'b0) begin fails++; $display("FAIL rst_ctl got %b exp 00000", {mem_req, mem_busy, mem_done, mem_err, mem_wen}); end
    tests++; if ({ir_out, mdr_out, mem_addr} !== 48'h0) begin fails++; $display("FAIL rst_regs got %h exp 0", {ir_out, mdr_out, mem_addr}); end
    tick();
    reset = 1;
    tick();
    tests++; if (mem_busy !== 1'b0) begin fails++; $display("FAIL rst_idle busy got %b exp 0", mem_busy); end
  endtask
  task automatic test_read();
    addr_in = 16'h0040; mem_we = 0; IRw = 1; mem_start = 1;
    tick();
    mem_start = 0;
    tests++; if ({mem_req, mem_busy, mem_done, mem_wen} !== 4'b1100) begin fails++; $display("FAIL rd_access got %b exp 1100", {mem_req, mem_busy, mem_done, mem_wen}); end
    tests++; if (mem_addr !== 16'h0040) begin fails++; $display("FAIL rd_addr got %h exp 0040", mem_addr); end
    mem_ready = 1; mem_rdata = 16'h1234;
    tick();
    mem_ready = 0;
    tests++; if ({mem_req, mem_busy, mem_done} !== 3'b001) begin fails++; $display("FAIL rd_done got %b exp 001", {mem_req, mem_busy, mem_done}); end
    tests++; if ({ir_out, mdr_out, mem_out} !== {3{16'h1234}}) begin fails++; $display("FAIL rd_data got %h exp 123412341234", {ir_out, mdr_out, mem_out}); end
    tick();
    tests++; if (mem_done !== 1'b0) begin fails++; $display("FAIL rd_pulse got %b exp 0", mem_done); end
  endtask
  task automatic test_write();
    addr_in = 16'h0010; wdata_in = 16'hBEEF; mem_we = 1; IRw = 1; mem_start = 1;
    tick();
    mem_start = 0; addr_in = 16'h0099; wdata_in = 16'h0000; mem_rdata = 16'hDEAD;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({mem_req, mem_wen, mem_addr, mem_wdata} !== {2'b11, 16'h0010, 16'hBEEF}) begin fails++; $display("FAIL wr_wait%0d got %b %b %h %h exp 1 1 0010 beef", i, mem_req, mem_wen, mem_addr, mem_wdata); end
    end
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tests++; if (mem_done !== 1'b1) begin fails++; $display("FAIL wr_done got %b exp 1", mem_done); end
    tests++; if ({ir_out, mdr_out} !== {2{16'h1234}}) begin fails++; $display("FAIL wr_keep got %h exp 12341234", {ir_out, mdr_out}); end
  endtask
  task automatic test_back_to_back();
    addr_in = 16'h0022; mem_we = 0; IRw = 0; mem_start = 1;
    tick();
    tests++; if ({mem_busy, mem_done, mem_addr} !== {2'b10, 16'h0022}) begin fails++; $display("FAIL b2b_enter got %b %b %h exp 1 0 0022", mem_busy, mem_done, mem_addr); end
    addr_in = 16'h0033;
    tick();
    tests++; if ({mem_busy, mem_addr} !== {1'b1, 16'h0022}) begin fails++; $display("FAIL b2b_ignore got %b %h exp 1 0022", mem_busy, mem_addr); end
    mem_start = 0; mem_ready = 1; mem_rdata = 16'h5A5A;
    tick();
    tests++; if ({mem_done, mdr_out, ir_out} !== {1'b1, 16'h5A5A, 16'h1234}) begin fails++; $display("FAIL b2b_rd1 got %b %h %h exp 1 5a5a 1234", mem_done, mdr_out, ir_out); end
    addr_in = 16'h0044; IRw = 1; mem_start = 1; mem_ready = 0;
    tick();
    mem_start = 0;
    tests++; if ({mem_busy, mem_done, mem_addr} !== {2'b10, 16'h0044}) begin fails++; $display("FAIL b2b_reenter got %b %b %h exp 1 0 0044", mem_busy, mem_done, mem_addr); end
    mem_ready = 1; mem_rdata = 16'h0F0F;
    tick();
    mem_ready = 0;
    tests++; if ({mem_done, ir_out, mdr_out} !== {1'b1, 16'h0F0F, 16'h0F0F}) begin fails++; $display("FAIL b2b_rd2 got %b %h %h exp 1 0f0f 0f0f", mem_done, ir_out, mdr_out); end
    tick();
  endtask
  task automatic test_stall();
    addr_in = 16'h0050; mem_we = 0; IRw = 1; mem_start = 1; mem_rdata = 16'hAAAA;
    tick();
    mem_start = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) tick();
    tests++; if ({mem_busy, mem_err} !== 2'b10) begin fails++; $display("FAIL to_pre got %b exp 10", {mem_busy, mem_err}); end
    tick();
    tests++; if ({mem_req, mem_done, mem_err} !== 3'b011) begin fails++; $display("FAIL to_fire got %b exp 011", {mem_req, mem_done, mem_err}); end
    tests++; if ({ir_out, mdr_out} !== {2{16'h0F0F}}) begin fails++; $display("FAIL to_keep got %h exp 0f0f0f0f", {ir_out, mdr_out}); end
    tick();
    tests++; if ({mem_done, mem_err} !== 2'b01) begin fails++; $display("FAIL to_hold got %b exp 01", {mem_done, mem_err}); end
    mem_start = 1;
    tick();
    mem_start = 0;
    tests++; if ({mem_busy, mem_err} !== 2'b10) begin fails++; $display("FAIL to_clear got %b exp 10", {mem_busy, mem_err}); end
`else
    for (int i = 0; i < 10; i++) tick();
    tests++; if ({mem_req, mem_busy, mem_err} !== 3'b110) begin fails++; $display("FAIL stall_wait got %b exp 110", {mem_req, mem_busy, mem_err}); end
`endif
    mem_ready = 1;
    tick();
    mem_ready = 0;
    tests++; if ({mem_done, mem_err, ir_out} !== {2'b10, 16'hAAAA}) begin fails++; $display("FAIL stall_end got %b %b %h exp 1 0 aaaa", mem_done, mem_err, ir_out); end
    tick();
  endtask
  task automatic test_reset_mid();
    addr_in = 16'h0060; mem_we = 0; IRw = 1; mem_start = 1; mem_rdata = 16'h7777;
    tick();
    mem_start = 0;
    #2 reset = 0;
    #1;
    tests++; if ({mem_req, mem_busy} !== 2'b00) begin fails++; $display("FAIL rmid_req got %b exp 00", {mem_req, mem_busy}); end
    tests++; if ({ir_out, mdr_out, mem_addr} !== 48'h0) begin fails++; $display("FAIL rmid_regs got %h exp 0", {ir_out, mdr_out, mem_addr}); end
    mem_ready = 1;
    tick();
    reset = 1;
    tick();
    mem_ready = 0;
    tests++; if ({mem_busy, mem_done, mdr_out} !== {2'b00, 16'h0}) begin fails++; $display("FAIL rmid_idle got %b %b %h exp 0 0 0000", mem_busy, mem_done, mdr_out); end
  endtask
  initial begin
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
